// File: rtl/score_display_ctrl.sv
// Score/high-score owner and seven-segment value selector with debounced high-score button.
// Optional new-record blink is enabled by defining NEW_RECORD_BLINK_EN.
module score_display_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES   = 500000,
    parameter int unsigned HS_TIMEOUT_CYCLES = 300000000,
    parameter int unsigned BLINK_CYCLES      = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs_btn,
    input  logic        point_inc,
    input  logic        game_start,
    input  logic        game_over,
    output logic [31:0] val,
    output logic [31:0] points,
    output logic [31:0] highscore,
    output logic        show_hs,
    output logic        new_record,
    output logic        blank,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        SHOW_PTS = 2'd0,
        SHOW_HS  = 2'd1,
        RECORD   = 2'd2
    } state_t;

    localparam logic [31:0] DEB_LAST = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] TO_LAST  = 32'(HS_TIMEOUT_CYCLES - 1);

    logic        sync1_q, sync2_q;
    logic        db_q, db_d;
    logic [31:0] db_cnt_q, db_cnt_d;
    logic        hs_press_q;

    state_t      state_q, state_d;
    logic [31:0] to_cnt_q, to_cnt_d;
    logic [31:0] points_q, points_d;
    logic [31:0] hs_q, hs_d;
    logic        nr_q, nr_d;
    logic        show_hs_q;
    logic [31:0] val_q, val_d;
    logic        is_record;

    // Debounce: the counter tracks consecutive cycles where the synchronised input disagrees.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        if (sync2_q != db_q) begin
            if (db_cnt_q == DEB_LAST) begin
                db_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 32'd1;
            end
        end
    end

    assign is_record = game_over & ~game_start & (points_q > hs_q);

    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        case (state_q)
            SHOW_PTS: begin
                if (is_record) begin
                    state_d = RECORD;
                end else if (hs_press_q) begin
                    state_d  = SHOW_HS;
                    to_cnt_d = '0;
                end
            end
            SHOW_HS: begin
                if (is_record) begin
                    state_d = RECORD;
                end else if (hs_press_q || game_start || (to_cnt_q == TO_LAST)) begin
                    state_d = SHOW_PTS;
                end else begin
                    to_cnt_d = to_cnt_q + 32'd1;
                end
            end
            RECORD: begin
                if (hs_press_q || game_start) begin
                    state_d = SHOW_PTS;
                end
            end
            default: state_d = SHOW_PTS;
        endcase
    end

    // Event priority: game_start, then game_over, then point_inc.
    always_comb begin
        points_d = points_q;
        hs_d     = hs_q;
        nr_d     = nr_q;
        if (game_start) begin
            points_d = '0;
            nr_d     = 1'b0;
        end else if (game_over) begin
            if (is_record) begin
                hs_d = points_q;
                nr_d = 1'b1;
            end
        end else if (point_inc && (points_q != 32'hFFFF_FFFF)) begin
            points_d = points_q + 32'd1;
        end
        val_d = (state_d != SHOW_PTS) ? hs_d : points_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_q       <= 1'b0;
            db_cnt_q   <= '0;
            hs_press_q <= 1'b0;
            state_q    <= SHOW_PTS;
            to_cnt_q   <= '0;
            points_q   <= '0;
            hs_q       <= '0;
            nr_q       <= 1'b0;
            show_hs_q  <= 1'b0;
            val_q      <= '0;
        end else begin
            sync1_q    <= hs_btn;
            sync2_q    <= sync1_q;
            db_q       <= db_d;
            db_cnt_q   <= db_cnt_d;
            hs_press_q <= db_d & ~db_q;
            state_q    <= state_d;
            to_cnt_q   <= to_cnt_d;
            points_q   <= points_d;
            hs_q       <= hs_d;
            nr_q       <= nr_d;
            show_hs_q  <= (state_d != SHOW_PTS);
            val_q      <= val_d;
        end
    end

`ifdef NEW_RECORD_BLINK_EN
    localparam logic [31:0] BLINK_LAST = 32'(BLINK_CYCLES - 1);

    logic [31:0] blink_cnt_q, blink_cnt_d;
    logic        blank_q, blank_d;

    // Blank starts high on entering RECORD and toggles every BLINK_CYCLES while there.
    always_comb begin
        blink_cnt_d = '0;
        blank_d     = 1'b0;
        if (state_d == RECORD) begin
            if (state_q != RECORD) begin
                blank_d = 1'b1;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blank_d = ~blank_q;
            end else begin
                blank_d     = blank_q;
                blink_cnt_d = blink_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blank_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blank_q     <= blank_d;
        end
    end

    assign blank = blank_q;
`else
    assign blank = 1'b0;

    // BLINK_CYCLES only matters when the blink feature is built in.
    if (BLINK_CYCLES == 0) begin : g_blink_param_unused
    end
`endif

    assign val        = val_q;
    assign points     = points_q;
    assign highscore  = hs_q;
    assign show_hs    = show_hs_q;
    assign new_record = nr_q;
    assign dbg_state  = state_q;

endmodule
